// File: rtl/turbo_encoder_if.sv
// Handshake and bus bundle for turbo_encoder_core: block control, the two
// serial input streams, the registered symbol output and the status flags.
interface turbo_encoder_if #(
  parameter int unsigned KW = 13
) ();
  logic          start;
  logic [KW-1:0] k_len;
  logic          rate_half;
  logic          ck1;
  logic          ck1_valid;
  logic          ck1_ready;
  logic          ck2;
  logic          ck2_valid;
  logic          ck2_ready;
  logic          xk1;
  logic          zk1;
  logic          xk2;
  logic          zk2;
  logic [3:0]    out_mask;
  logic          out_tail;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;
  logic          err_klen;

  // Source side: controls the block and feeds both streams, consumes symbols.
  modport master (
    output start, k_len, rate_half, ck1, ck1_valid, ck2, ck2_valid, out_ready,
    input  ck1_ready, ck2_ready, xk1, zk1, xk2, zk2, out_mask, out_tail,
           out_valid, busy, done, err_klen
  );

  // Encoder side.
  modport slave (
    input  start, k_len, rate_half, ck1, ck1_valid, ck2, ck2_valid, out_ready,
    output ck1_ready, ck2_ready, xk1, zk1, xk2, zk2, out_mask, out_tail,
           out_valid, busy, done, err_klen
  );
endinterface

// File: rtl/turbo_encoder_core.sv
// Turbo encoder core: two 8-state RSC encoders (g0=13, g1=15 octal) stepped in
// lockstep, systematic-bit FIFO on the direct stream, trellis termination and
// a registered valid/ready symbol output.
// Optional feature macro: TURBO_RATE_HALF_EN enables rate-1/2 puncturing of
// data symbols; without it rate_half is ignored and data masks are 1111.
module turbo_encoder_core #(
  parameter int unsigned KMAX  = 6144,
  parameter int unsigned KW    = 13,
  parameter int unsigned DEPTH = 512,
  parameter int unsigned AW    = 9
) (
  input  logic            clk,
  input  logic            aclr,
  turbo_encoder_if.slave  bus
);

  localparam int unsigned CW   = AW + 1;
  localparam int unsigned KMIN = 40;

  typedef enum logic [2:0] {IDLE, ENC, TAIL1, TAIL2, DONE} state_t;

  state_t          state, state_nxt;
  logic [DEPTH-1:0] mem;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            full_c, empty_c, push_c, pop_c, head_c, adv_c, legal_c;
  logic [KW-1:0]   cnt, cnt_nxt, klen_q, klen_nxt;
  logic [1:0]      tcnt, tcnt_nxt;
  logic [2:0]      s1, s1_nxt, s2, s2_nxt;
  logic [3:0]      r1, r2, dmask_c;
  logic            rate_q, rate_nxt;
  logic [3:0]      data_q, data_nxt, mask_q, mask_nxt;
  logic            tail_q, tail_nxt, valid_q, valid_nxt;
  logic            busy_q, busy_nxt, done_q, done_nxt, err_q, err_nxt;
  logic            ck2_ready_c;

  // One RSC step: returns {parity, next state}; state is {s0,s1,s2}.
  function automatic logic [3:0] rsc_step(input logic c, input logic [2:0] s);
    logic a;
    a = c ^ s[1] ^ s[0];
    return {a ^ s[2] ^ s[0], a, s[2], s[1]};
  endfunction

  assign full_c  = (count == CW'(DEPTH));
  assign empty_c = (count == CW'(0));
  assign push_c  = bus.ck1_valid & ~full_c;
  assign head_c  = mem[rd_ptr];
  assign adv_c   = ~valid_q | bus.out_ready;
  assign legal_c = (bus.k_len >= KW'(KMIN)) && (bus.k_len <= KW'(KMAX));
  assign pop_c   = ck2_ready_c;

`ifdef TURBO_RATE_HALF_EN
  assign dmask_c = rate_q ? (cnt[0] ? 4'b1010 : 4'b1100) : 4'b1111;
`else
  logic rate_unused;
  assign dmask_c     = 4'b1111;
  assign rate_unused = rate_q;
`endif

  // Systematic FIFO: circular bit buffer with occupancy counter.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c) begin
        mem[wr_ptr] <= bus.ck1;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_c) rd_ptr <= rd_ptr + AW'(1);
      case ({push_c, pop_c})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Block sequencing, encoder stepping and next output symbol.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    tcnt_nxt    = tcnt;
    klen_nxt    = klen_q;
    rate_nxt    = rate_q;
    s1_nxt      = s1;
    s2_nxt      = s2;
    data_nxt    = data_q;
    mask_nxt    = mask_q;
    tail_nxt    = tail_q;
    valid_nxt   = valid_q & ~bus.out_ready;
    busy_nxt    = busy_q;
    done_nxt    = 1'b0;
    err_nxt     = err_q;
    ck2_ready_c = 1'b0;
    r1          = '0;
    r2          = '0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (legal_c) begin
            state_nxt = ENC;
            klen_nxt  = bus.k_len;
            rate_nxt  = bus.rate_half;
            cnt_nxt   = '0;
            s1_nxt    = '0;
            s2_nxt    = '0;
            busy_nxt  = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      ENC: begin
        if (!empty_c && bus.ck2_valid && adv_c) begin
          ck2_ready_c = 1'b1;
          r1          = rsc_step(head_c, s1);
          r2          = rsc_step(bus.ck2, s2);
          s1_nxt      = r1[2:0];
          s2_nxt      = r2[2:0];
          data_nxt    = {head_c, r1[3], bus.ck2, r2[3]} & dmask_c;
          mask_nxt    = dmask_c;
          tail_nxt    = 1'b0;
          valid_nxt   = 1'b1;
          cnt_nxt     = cnt + KW'(1);
          tcnt_nxt    = '0;
          if (cnt_nxt == klen_q) state_nxt = TAIL1;
        end
      end
      TAIL1: begin
        if (adv_c) begin
          r1        = rsc_step(s1[1] ^ s1[0], s1);
          s1_nxt    = r1[2:0];
          data_nxt  = {s1[1] ^ s1[0], r1[3], 2'b00};
          mask_nxt  = 4'b1100;
          tail_nxt  = 1'b1;
          valid_nxt = 1'b1;
          tcnt_nxt  = tcnt + 2'd1;
          if (tcnt == 2'd2) begin
            tcnt_nxt  = '0;
            state_nxt = TAIL2;
          end
        end
      end
      TAIL2: begin
        if (adv_c) begin
          r2        = rsc_step(s2[1] ^ s2[0], s2);
          s2_nxt    = r2[2:0];
          data_nxt  = {2'b00, s2[1] ^ s2[0], r2[3]};
          mask_nxt  = 4'b0011;
          tail_nxt  = 1'b1;
          valid_nxt = 1'b1;
          tcnt_nxt  = tcnt + 2'd1;
          if (tcnt == 2'd2) begin
            tcnt_nxt  = '0;
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        if (valid_q && bus.out_ready) begin
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state   <= IDLE;
      cnt     <= '0;
      tcnt    <= '0;
      klen_q  <= '0;
      rate_q  <= 1'b0;
      s1      <= '0;
      s2      <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      tail_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      tcnt    <= tcnt_nxt;
      klen_q  <= klen_nxt;
      rate_q  <= rate_nxt;
      s1      <= s1_nxt;
      s2      <= s2_nxt;
      data_q  <= data_nxt;
      mask_q  <= mask_nxt;
      tail_q  <= tail_nxt;
      valid_q <= valid_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
      err_q   <= err_nxt;
    end
  end

  assign bus.ck1_ready = ~full_c;
  assign bus.ck2_ready = ck2_ready_c;
  assign bus.xk1       = data_q[3];
  assign bus.zk1       = data_q[2];
  assign bus.xk2       = data_q[1];
  assign bus.zk2       = data_q[0];
  assign bus.out_mask  = mask_q;
  assign bus.out_tail  = tail_q;
  assign bus.out_valid = valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err_klen  = err_q;

endmodule

// File: tb/tb_turbo_encoder_core.sv
// Directed bench for turbo_encoder_core with a recurrence-form golden model.
module tb_turbo_encoder_core;

  localparam int unsigned KW    = 13;
  localparam int unsigned DEPTH = 512;
`ifdef TURBO_RATE_HALF_EN
  localparam bit RH_EN = 1'b1;
`else
  localparam bit RH_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic aclr;
  int   n_chk = 0;
  int   n_fail = 0;

  bit         u1 [0:127];
  bit         u2 [0:127];
  logic [8:0] exp_sym [0:127];
  logic [8:0] rec [0:127];
  int         n_exp;

  turbo_encoder_if #(.KW(KW)) bus ();

  turbo_encoder_core #(.KMAX(6144), .KW(KW), .DEPTH(DEPTH), .AW(9)) dut (
    .clk  (clk),
    .aclr (aclr),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Golden model: a_n = c ^ a_{n-2} ^ a_{n-3}, z_n = a_n ^ a_{n-1} ^ a_{n-3}.
  task automatic build_exp(input int k, input bit rh);
    bit [2:0] h1, h2;
    bit       a1, a2, x, z;
    bit [3:0] m, d;
    h1 = '0;
    h2 = '0;
    n_exp = 0;
    for (int n = 0; n < k; n++) begin
      a1 = u1[n] ^ h1[1] ^ h1[2];
      a2 = u2[n] ^ h2[1] ^ h2[2];
      d  = {u1[n], a1 ^ h1[0] ^ h1[2], u2[n], a2 ^ h2[0] ^ h2[2]};
      h1 = {h1[1], h1[0], a1};
      h2 = {h2[1], h2[0], a2};
      m  = (RH_EN && rh) ? ((n % 2 == 0) ? 4'b1100 : 4'b1010) : 4'b1111;
      exp_sym[n_exp] = {d & m, m, 1'b0};
      n_exp++;
    end
    for (int t = 0; t < 3; t++) begin
      x = h1[1] ^ h1[2];
      z = h1[0] ^ h1[2];
      h1 = {h1[1], h1[0], 1'b0};
      exp_sym[n_exp] = {x, z, 2'b00, 4'b1100, 1'b1};
      n_exp++;
    end
    for (int t = 0; t < 3; t++) begin
      x = h2[1] ^ h2[2];
      z = h2[0] ^ h2[2];
      h2 = {h2[1], h2[0], 1'b0};
      exp_sym[n_exp] = {2'b00, x, z, 4'b0011, 1'b1};
      n_exp++;
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_data"}, {bus.xk1, bus.zk1, bus.xk2, bus.zk2}, 0);
    chk({tag, "_mask"}, bus.out_mask, 0);
    chk({tag, "_tail"}, bus.out_tail, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_err"}, bus.err_klen, 0);
    chk({tag, "_ck1_ready"}, bus.ck1_ready, 1);
    chk({tag, "_ck2_ready"}, bus.ck2_ready, 0);
  endtask

  task automatic fill_bits(input int mode);
    for (int i = 0; i < 128; i++) begin
      case (mode)
        0:       begin u1[i] = 1'b0; u2[i] = 1'b0; end
        1:       begin u1[i] = (i == 0); u2[i] = 1'b0; end
        default: begin u1[i] = 1'($urandom_range(0, 1)); u2[i] = 1'($urandom_range(0, 1)); end
      endcase
    end
  endtask

  // Preload ck1, start a block, stream ck2 and compare every accepted symbol.
  task automatic run_block(input string tag, input int k, input bit rh,
                           input int gap_at, input bit rnd, input int stop_after);
    int sent, got, cyc, gap_left, target;
    logic [8:0] sym;
    build_exp(k, rh);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      bus.ck1 = u1[i];
      bus.ck1_valid = 1'b1;
    end
    @(negedge clk);
    bus.ck1_valid = 1'b0;
    bus.start = 1'b1;
    bus.k_len = KW'(k);
    bus.rate_half = rh;
    @(negedge clk);
    bus.start = 1'b0;
    #1 chk({tag, "_busy_start"}, bus.busy, 1);
    sent = 0; got = 0; cyc = 0; gap_left = 10;
    target = (stop_after > 0) ? stop_after : n_exp;
    while (got < target && cyc < 4000) begin
      if (gap_at >= 0 && sent == gap_at && gap_left > 0) begin
        bus.ck2_valid = 1'b0;
        gap_left--;
      end else begin
        bus.ck2_valid = (sent < k);
      end
      bus.ck2 = (sent < k) ? u2[sent] : 1'b0;
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (bus.ck2_valid && bus.ck2_ready) sent++;
      if (bus.out_valid && bus.out_ready) begin
        sym = {bus.xk1, bus.zk1, bus.xk2, bus.zk2, bus.out_mask, bus.out_tail};
        rec[got] = sym;
        chk($sformatf("%s_sym%0d", tag, got), sym, exp_sym[got]);
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.ck2_valid = 1'b0;
    bus.out_ready = 1'b1;
    chk({tag, "_symbol_count"}, got, target);
    if (stop_after == 0) begin
      #1;
      chk({tag, "_done_pulse"}, bus.done, 1);
      chk({tag, "_busy_end"}, bus.busy, 0);
      chk({tag, "_no_extra"}, bus.out_valid, 0);
      @(negedge clk);
      #1 chk({tag, "_done_single"}, bus.done, 0);
    end
  endtask

  initial begin
    int acc;
    logic [6:0] zref;
    bus.start = 1'b0; bus.k_len = '0; bus.rate_half = 1'b0;
    bus.ck1 = 1'b0; bus.ck1_valid = 1'b0; bus.ck2 = 1'b0; bus.ck2_valid = 1'b0;
    bus.out_ready = 1'b1;
    aclr = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_reset("reset");
    @(negedge clk);
    aclr = 1'b1;

    // All-zero block, full-rate output.
    fill_bits(0);
    run_block("zeros", 40, 1'b0, -1, 1'b0, 0);

    // Impulse response on encoder 1.
    fill_bits(1);
    run_block("impulse", 40, 1'b0, -1, 1'b0, 0);
    zref = 7'b1111001;
    for (int i = 0; i < 7; i++) chk($sformatf("impulse_zk1_%0d", i), rec[i][7], zref[6 - i]);

    // Random data, ck2 stall and random backpressure.
    fill_bits(2);
    run_block("stall", 60, 1'b0, 25, 1'b1, 0);

    // Puncturing request (ignored when the feature is not built in).
    fill_bits(2);
    run_block("punct", 40, 1'b1, -1, 1'b1, 0);

    // FIFO fill with no block running.
    acc = 0;
    for (int i = 0; i < DEPTH + 5; i++) begin
      @(negedge clk);
      bus.ck1 = 1'(i % 2);
      bus.ck1_valid = 1'b1;
      bus.ck2_valid = 1'b1;
      #1 if (bus.ck1_ready) acc++;
    end
    @(negedge clk);
    bus.ck1_valid = 1'b0;
    #1;
    chk("fill_accepted", acc, DEPTH);
    chk("fill_ck1_ready", bus.ck1_ready, 0);
    chk("fill_ck2_ready", bus.ck2_ready, 0);
    chk("fill_out_valid", bus.out_valid, 0);
    bus.ck2_valid = 1'b0;
    aclr = 1'b0;
    #1 check_reset("fill_rst");
    @(negedge clk);
    aclr = 1'b1;

    // Abandon a block mid-way, then run a clean one.
    fill_bits(2);
    run_block("abort", 41, 1'b0, -1, 1'b0, 20);
    aclr = 1'b0;
    #1 check_reset("abort_rst");
    @(negedge clk);
    aclr = 1'b1;
    fill_bits(2);
    run_block("after_abort", 41, 1'b0, -1, 1'b0, 0);

    // Illegal block length.
    @(negedge clk);
    bus.start = 1'b1;
    bus.k_len = KW'(39);
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    chk("klen39_err", bus.err_klen, 1);
    chk("klen39_busy", bus.busy, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("klen39_err_sticky", bus.err_klen, 1);
    chk("klen39_idle_out", bus.out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
